rms_multi: RTL

Multi-channel successor to the single-stream RMS engine. It keeps an independent sum-of-squares accumulator and sample counter for each of NCH channels. On a result command it queues a {sum, count} request to one shared iterative divide + square-root engine, which replaces the fully unrolled pipelines. Results go to a tagged output FIFO drained with the same pullout/stopout handshake. Input backpressure (stopin) is new.

---
 rtl/rms_multi.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rms_multi.sv
// rms_multi: per-channel sum-of-squares accumulators feeding a shared
// iterative divide + square-root engine, with a tagged output FIFO.
module rms_multi #(
  parameter int DW        = 32,
  parameter int NCH       = 4,
  parameter int CNTW      = 10,
  parameter int ACCW      = 2*DW+8,
  parameter int REQ_DEPTH = 4,
  parameter int OUT_DEPTH = 8,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pushin,
  input  logic [1:0]      cmdin,
  input  logic [CHW-1:0]  chin,
  input  logic [DW-1:0]   Xin,
  output logic            stopin,
  input  logic            pullout,
  output logic            stopout,
  output logic [DW-1:0]   Xout,
  output logic [CHW-1:0]  chout
);

  localparam int QAW = $clog2(REQ_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int BCW = $clog2(ACCW);

  typedef enum logic [2:0] {IDLE, DIV, SQRT, ERR, WR} state_t;

  // pipeline stage registers
  logic            v0, v1;
  logic [1:0]      c0, c1;
  logic [CHW-1:0]  h0, h1;
  logic [DW-1:0]   x0;
  logic [2*DW-1:0] sq1;

  // per-channel state
  logic [ACCW-1:0] acc [NCH];
  logic [CNTW-1:0] cnt [NCH];

  // request queue
  logic [CHW-1:0]  q_ch  [REQ_DEPTH];
  logic [ACCW-1:0] q_acc [REQ_DEPTH];
  logic [CNTW-1:0] q_cnt [REQ_DEPTH];
  logic [QAW:0]    q_wp, q_rp, q_count;
  logic [QAW+1:0]  pend;
  logic            q_empty, enq;

  // engine
  state_t          state, state_nx;
  logic            pop, fifo_wr;
  logic [CHW-1:0]  e_ch;
  logic [ACCW-1:0] dq, dq_nx;
  logic [CNTW-1:0] divisor, rem, rem_nx;
  logic [CNTW:0]   rs;
  logic            ge_d, ge_s;
  logic [2*DW-1:0] q_sat, rad;
  logic [DW+1:0]   srem, srem_nx, trial;
  logic [DW+3:0]   sr_sh;
  logic [DW-1:0]   root;
  logic [BCW-1:0]  bitcnt;

  // S2 arithmetic
  logic [ACCW-1:0] sq_ext, acc_sum, acc_dif;
  logic [CNTW-1:0] cnt_inc, cnt_dec;

  // output FIFO
  logic [CHW-1:0]  o_ch [OUT_DEPTH];
  logic [DW-1:0]   o_x  [OUT_DEPTH];
  logic [OAW:0]    o_wp, o_rp;
  logic            o_empty, o_full, o_pop;

  // S0/S1: capture accepted commands and square the sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0; c0 <= 2'd0; h0 <= '0; x0 <= '0;
      v1 <= 1'b0; c1 <= 2'd0; h1 <= '0; sq1 <= '0;
    end else begin
      v0  <= pushin & ~stopin;
      c0  <= cmdin;
      h0  <= chin;
      x0  <= Xin;
      v1  <= v0;
      c1  <= c0;
      h1  <= h0;
      sq1 <= x0 * x0;
    end
  end

  // S2 update values; the write lands before the next read, so no hazard
  always_comb begin
    sq_ext  = {{(ACCW-2*DW){1'b0}}, sq1};
    acc_sum = acc[h1] + sq_ext;
    acc_dif = acc[h1] - sq_ext;
    cnt_inc = cnt[h1] + {{(CNTW-1){1'b0}}, 1'b1};
    cnt_dec = cnt[h1] - {{(CNTW-1){1'b0}}, 1'b1};
    enq     = v1 & c1[1];
  end

  // S2: per-channel accumulator and counter update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (v1) begin
      case (c1)
        2'd0, 2'd2: begin acc[h1] <= acc_sum; cnt[h1] <= cnt_inc; end
        2'd1:       begin acc[h1] <= acc_dif; cnt[h1] <= cnt_dec; end
        2'd3:       begin acc[h1] <= '0;      cnt[h1] <= '0;      end
        default:    begin acc[h1] <= acc[h1]; cnt[h1] <= cnt[h1]; end
      endcase
    end
  end

  // request queue storage and write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_wp <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        q_ch[i] <= '0; q_acc[i] <= '0; q_cnt[i] <= '0;
      end
    end else if (enq) begin
      q_ch[q_wp[QAW-1:0]]  <= h1;
      q_acc[q_wp[QAW-1:0]] <= acc_sum;
      q_cnt[q_wp[QAW-1:0]] <= cnt_inc;
      q_wp <= q_wp + {{QAW{1'b0}}, 1'b1};
    end
  end

  // backpressure counts emits still in flight so the queue cannot overflow
  always_comb begin
    q_count = q_wp - q_rp;
    q_empty = (q_count == {(QAW+1){1'b0}});
    pend    = {1'b0, q_count} + {{(QAW+1){1'b0}}, v0 & c0[1]}
                              + {{(QAW+1){1'b0}}, v1 & c1[1]};
    stopin  = (pend >= (QAW+2)'(REQ_DEPTH));
  end

  // one restoring-divide step and one root-digit step
  always_comb begin
    rs      = {rem, dq[ACCW-1]};
    ge_d    = (rs >= {1'b0, divisor});
    rem_nx  = CNTW'(rs - (ge_d ? {1'b0, divisor} : {(CNTW+1){1'b0}}));
    dq_nx   = {dq[ACCW-2:0], ge_d};
    q_sat   = (|dq_nx[ACCW-1:2*DW]) ? {(2*DW){1'b1}} : dq_nx[2*DW-1:0];
    trial   = {root, 2'b01};
    sr_sh   = {srem, rad[2*DW-1:2*DW-2]};
    ge_s    = (sr_sh >= {2'b00, trial});
    srem_nx = (DW+2)'(sr_sh - (ge_s ? {2'b00, trial} : {(DW+4){1'b0}}));
  end

  // engine state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // engine next-state and control
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    fifo_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop = 1'b1;
          if ((q_cnt[q_rp[QAW-1:0]] == {CNTW{1'b0}}) || q_acc[q_rp[QAW-1:0]][ACCW-1])
            state_nx = ERR;
          else
            state_nx = DIV;
        end else begin
          state_nx = IDLE;
        end
      end
      DIV:  state_nx = (bitcnt == {BCW{1'b0}}) ? SQRT : DIV;
      SQRT: state_nx = (bitcnt == {BCW{1'b0}}) ? WR : SQRT;
      ERR:  state_nx = WR;
      WR: begin
        if (!o_full) begin
          fifo_wr  = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = WR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // engine datapath and queue read pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rp <= '0; e_ch <= '0; dq <= '0; divisor <= '0; rem <= '0;
      rad <= '0; srem <= '0; root <= '0; bitcnt <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          q_rp    <= q_rp + {{QAW{1'b0}}, 1'b1};
          e_ch    <= q_ch[q_rp[QAW-1:0]];
          dq      <= q_acc[q_rp[QAW-1:0]];
          divisor <= q_cnt[q_rp[QAW-1:0]];
          rem     <= '0;
          root    <= '0;
          bitcnt  <= BCW'(ACCW-1);
        end
        DIV: begin
          dq  <= dq_nx;
          rem <= rem_nx;
          if (bitcnt == {BCW{1'b0}}) begin
            rad    <= q_sat;
            srem   <= '0;
            root   <= '0;
            bitcnt <= BCW'(DW-1);
          end else begin
            bitcnt <= bitcnt - {{(BCW-1){1'b0}}, 1'b1};
          end
        end
        SQRT: begin
          srem <= srem_nx;
          root <= {root[DW-2:0], ge_s};
          rad  <= {rad[2*DW-3:0], 2'b00};
          if (bitcnt != {BCW{1'b0}})
            bitcnt <= bitcnt - {{(BCW-1){1'b0}}, 1'b1};
        end
        ERR:     root <= '0;
        default: root <= root;
      endcase
    end
  end

  // output FIFO status and head view
  always_comb begin
    o_empty = (o_wp == o_rp);
    o_full  = (o_wp[OAW] != o_rp[OAW]) && (o_wp[OAW-1:0] == o_rp[OAW-1:0]);
    o_pop   = pullout & ~o_empty;
    stopout = o_empty;
    Xout    = o_x[o_rp[OAW-1:0]];
    chout   = o_ch[o_rp[OAW-1:0]];
  end

  // output FIFO storage and pointers; simultaneous push and pop both happen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_wp <= '0;
      o_rp <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        o_ch[i] <= '0; o_x[i] <= '0;
      end
    end else begin
      if (fifo_wr) begin
        o_ch[o_wp[OAW-1:0]] <= e_ch;
        o_x[o_wp[OAW-1:0]]  <= root;
        o_wp <= o_wp + {{OAW{1'b0}}, 1'b1};
      end
      if (o_pop)
        o_rp <= o_rp + {{OAW{1'b0}}, 1'b1};
    end
  end

endmodule
